// File: rtl/sw_data_feeder.sv
// sw_data_feeder: host-side feeder for a systolic Smith-Waterman array.
// Stores the S sequence as PE_SIZE-symbol chunks and holds the T sequence,
// with its per-column V/F scores, in a circular show-ahead FIFO. Each pass
// serves one S chunk while the array pops T entries and returns updated ones.
// Returns are recycled into the FIFO, except on the final chunk's pass.
// Optional feature: define SW_DATA_FEEDER_ERR_EN for the sticky o_err flag.
module sw_data_feeder #(
  parameter int PE_SIZE     = 64,
  parameter int PE_SIZE_LOG = 6,
  parameter int VEF_BIT     = 16,
  parameter int S_CHUNKS    = 4,
  parameter int T_DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // host load
  input  logic                     i_s_valid,
  input  logic [1:0]               i_s_sym,
  input  logic                     i_s_last,
  input  logic                     i_t_load_valid,
  input  logic [1:0]               i_t_sym,
  input  logic                     i_t_load_last,
  output logic                     o_load_ready,
  // host status
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  // S chunk to the array
  input  logic                     i_update_s_w,
  output logic [2*PE_SIZE-1:0]     o_s,
  output logic                     o_s_last,
  output logic                     o_data_valid,
  output logic [PE_SIZE_LOG:0]     o_init_s_len,
  // T FIFO head to the array
  input  logic                     i_update_t_w,
  output logic [1:0]               o_t,
  output logic [VEF_BIT-1:0]       o_v,
  output logic [VEF_BIT-1:0]       o_f,
  output logic                     o_t_last,
  // returns from the array
  input  logic [1:0]               i_t,
  input  logic [VEF_BIT-1:0]       i_v,
  input  logic [VEF_BIT-1:0]       i_f,
  input  logic                     i_t_valid
);

  localparam int SW    = 2 * PE_SIZE;
  localparam int S_MAX = S_CHUNKS * PE_SIZE;
  localparam int SCW   = $clog2(S_MAX + 1);
  localparam int CW    = (S_CHUNKS > 1) ? $clog2(S_CHUNKS) : 1;
  localparam int PW    = $clog2(T_DEPTH);
  localparam int LW    = PW + 1;
  localparam int LENW  = PE_SIZE_LOG + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SERVE, ST_DONE} state_e;

  typedef struct packed {
    logic [1:0]         t;
    logic [VEF_BIT-1:0] v;
    logic [VEF_BIT-1:0] f;
  } t_entry_t;

  state_e state_q, state_d;

  // storage
  logic [SW-1:0] s_mem_q    [S_CHUNKS];
  t_entry_t      fifo_mem_q [T_DEPTH];

  // control registers
  logic [SCW-1:0] s_cnt_q, s_cnt_d;
  logic [LW-1:0]  t_len_q, t_len_d;
  logic           s_seen_last_q, s_seen_last_d;
  logic           t_seen_last_q, t_seen_last_d;
  logic [CW-1:0]  chunk_q, chunk_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  occ_q, occ_d;
  logic [LW-1:0]  pop_cnt_q, pop_cnt_d;
  logic [LW-1:0]  ret_cnt_q, ret_cnt_d;

  // decoded conditions
  logic                   in_load, serve, final_pass;
  logic                   fifo_empty, fifo_full, s_room;
  logic                   s_acc, t_acc, ret_push, push, pop, ret_final;
  logic [PE_SIZE_LOG-1:0] s_pos;
  logic [CW-1:0]          s_wr_chunk, last_chunk;
  logic [SCW-1:0]         s_cnt_m1;
  logic [LW-1:0]          t_len_m1;
  logic [LENW-1:0]        last_len;
  t_entry_t               push_entry, head;

  assign in_load    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign serve      = (state_q == ST_SERVE);
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == LW'(T_DEPTH));
  assign s_room     = (s_cnt_q < SCW'(S_MAX));

  assign o_load_ready = in_load && !fifo_full && s_room;
  assign s_acc        = i_s_valid && o_load_ready;
  assign t_acc        = i_t_load_valid && o_load_ready;

  assign s_pos      = s_cnt_q[PE_SIZE_LOG-1:0];
  assign s_wr_chunk = CW'(s_cnt_q >> PE_SIZE_LOG);
  assign s_cnt_m1   = s_cnt_q - SCW'(1);
  assign last_chunk = CW'(s_cnt_m1 >> PE_SIZE_LOG);
  assign last_len   = (s_pos == '0) ? LENW'(PE_SIZE) : LENW'(s_pos);
  assign final_pass = serve && (chunk_q == last_chunk);

  // Returns on the final chunk's pass are finished results and only counted.
  assign ret_push  = serve && i_t_valid && !final_pass;
  assign ret_final = final_pass && i_t_valid;
  assign push      = (t_acc || ret_push) && !fifo_full;
  assign pop       = i_update_t_w && !fifo_empty;
  assign t_len_m1  = t_len_q - LW'(1);

  assign push_entry = t_acc ? t_entry_t'{t: i_t_sym, v: '0, f: '0}
                            : t_entry_t'{t: i_t, v: i_v, f: i_f};

  // S chunk and FIFO views; gated so stale storage never leaks out.
  assign head         = fifo_mem_q[rd_ptr_q];
  assign o_s          = serve ? s_mem_q[chunk_q] : '0;
  assign o_s_last     = final_pass;
  assign o_init_s_len = !serve ? '0 : (final_pass ? last_len : LENW'(PE_SIZE));
  assign o_t          = fifo_empty ? '0 : head.t;
  assign o_v          = fifo_empty ? '0 : head.v;
  assign o_f          = fifo_empty ? '0 : head.f;
  assign o_t_last     = serve && !fifo_empty && (pop_cnt_q == t_len_m1);

  // Sequence storage: a chunk's first symbol clears the rest of the word,
  // so unused positions of a short final chunk read back as zero.
  // NOTE: data storage has no reset; it is only observed through gated outputs.
  always_ff @(posedge clk) begin
    if (s_acc) begin
      if (s_pos == '0) begin
        s_mem_q[s_wr_chunk] <= {i_s_sym, {(SW-2){1'b0}}};
      end else begin
        s_mem_q[s_wr_chunk][SW-1-2*int'(s_pos) -: 2] <= i_s_sym;
      end
    end
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Next-state FSM and status outputs.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_data_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_s_valid || i_t_load_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy = 1'b1;
        if (i_start && s_seen_last_q && t_seen_last_q) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        o_busy       = 1'b1;
        o_data_valid = 1'b1;
        if (ret_final && (ret_cnt_q + LW'(1) == t_len_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, pointers and chunk index; DONE clears everything for the next job.
  always_comb begin
    s_cnt_d       = s_cnt_q;
    t_len_d       = t_len_q;
    s_seen_last_d = s_seen_last_q;
    t_seen_last_d = t_seen_last_q;
    chunk_d       = chunk_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    pop_cnt_d     = pop_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    if (state_q == ST_DONE) begin
      s_cnt_d       = '0;
      t_len_d       = '0;
      s_seen_last_d = 1'b0;
      t_seen_last_d = 1'b0;
      chunk_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      occ_d         = '0;
      pop_cnt_d     = '0;
      ret_cnt_d     = '0;
    end else begin
      if (s_acc) begin
        s_cnt_d = s_cnt_q + SCW'(1);
        if (i_s_last) s_seen_last_d = 1'b1;
      end
      if (t_acc) begin
        t_len_d = t_len_q + LW'(1);
        if (i_t_load_last) t_seen_last_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + LW'(1);
        2'b01:   occ_d = occ_q - LW'(1);
        default: occ_d = occ_q;
      endcase
      if (serve && pop) begin
        pop_cnt_d = (pop_cnt_q == t_len_m1) ? '0 : pop_cnt_q + LW'(1);
      end
      if (serve && i_update_s_w && !final_pass) chunk_d = chunk_q + CW'(1);
      if (ret_final) ret_cnt_d = ret_cnt_q + LW'(1);
    end
  end

  // State and control registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      s_cnt_q       <= '0;
      t_len_q       <= '0;
      s_seen_last_q <= 1'b0;
      t_seen_last_q <= 1'b0;
      chunk_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      pop_cnt_q     <= '0;
      ret_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      s_cnt_q       <= s_cnt_d;
      t_len_q       <= t_len_d;
      s_seen_last_q <= s_seen_last_d;
      t_seen_last_q <= t_seen_last_d;
      chunk_q       <= chunk_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      pop_cnt_q     <= pop_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
    end
  end

`ifdef SW_DATA_FEEDER_ERR_EN
  logic err_q, err_d;

  // Sticky error: underflow, overflow, or a return while still loading.
  always_comb begin
    err_d = err_q;
    if ((i_update_t_w && fifo_empty) || (ret_push && fifo_full) ||
        (i_t_valid && in_load)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_sw_data_feeder.sv
// Self-checking bench for sw_data_feeder (default parameters). A queue-based
// model of the T FIFO and a symbol list for S predict every served chunk,
// every FIFO head and the done timing.
module tb_sw_data_feeder;

  localparam int PE    = 64;
  localparam int PEL   = 6;
  localparam int VEF   = 16;
  localparam int SCH   = 4;
  localparam int TD    = 256;
  localparam int SW    = 2 * PE;
  localparam int S_MAX = SCH * PE;
`ifdef SW_DATA_FEEDER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic           clk, rst_n;
  logic           i_s_valid, i_s_last, i_t_load_valid, i_t_load_last;
  logic [1:0]     i_s_sym, i_t_sym;
  logic           o_load_ready, i_start, o_busy, o_done, o_err;
  logic           i_update_s_w, o_s_last, o_data_valid;
  logic [SW-1:0]  o_s;
  logic [PEL:0]   o_init_s_len;
  logic           i_update_t_w, o_t_last, i_t_valid;
  logic [1:0]     o_t, i_t;
  logic [VEF-1:0] o_v, o_f, i_v, i_f;

  sw_data_feeder #(
    .PE_SIZE(PE), .PE_SIZE_LOG(PEL), .VEF_BIT(VEF), .S_CHUNKS(SCH), .T_DEPTH(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s_valid(i_s_valid), .i_s_sym(i_s_sym), .i_s_last(i_s_last),
    .i_t_load_valid(i_t_load_valid), .i_t_sym(i_t_sym), .i_t_load_last(i_t_load_last),
    .o_load_ready(o_load_ready),
    .i_start(i_start), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .i_update_s_w(i_update_s_w), .o_s(o_s), .o_s_last(o_s_last),
    .o_data_valid(o_data_valid), .o_init_s_len(o_init_s_len),
    .i_update_t_w(i_update_t_w), .o_t(o_t), .o_v(o_v), .o_f(o_f), .o_t_last(o_t_last),
    .i_t(i_t), .i_v(i_v), .i_f(i_f), .i_t_valid(i_t_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     t;
    logic [VEF-1:0] v;
    logic [VEF-1:0] f;
  } ent_t;

  typedef struct {
    int n_s;
    int n_t;
    int exp_chunks;
    int exp_last_len;
  } vec_t;

  logic [1:0] s_syms[$];
  ent_t       fifo_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_s_valid = 0; i_s_sym = 0; i_s_last = 0;
    i_t_load_valid = 0; i_t_sym = 0; i_t_load_last = 0;
    i_start = 0; i_update_s_w = 0; i_update_t_w = 0;
    i_t = 0; i_v = 0; i_f = 0; i_t_valid = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_o_s", o_s, '0);
    check("rst_o_s_last", o_s_last, 0);
    check("rst_data_valid", o_data_valid, 0);
    check("rst_init_s_len", o_init_s_len, 0);
    check("rst_o_t", o_t, 0);
    check("rst_o_v", o_v, 0);
    check("rst_o_f", o_f, 0);
    check("rst_t_last", o_t_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_load_ready", o_load_ready, 1);
  endtask

  // Reset asserted mid-cycle so the outputs must respond without a clock edge.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    check_reset_outputs();
    tick();
    rst_n = 1;
    tick();
  endtask

  // Expected chunk word: symbol k of the chunk at bits [2*(PE-k)-1 -: 2].
  function automatic logic [SW-1:0] pack_chunk(input int c, input int n_s);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < PE; k++) begin
      if (c * PE + k < n_s) r[SW-1-2*k -: 2] = s_syms[c*PE + k];
    end
    return r;
  endfunction

  task automatic load_s_all(input int n_s);
    for (int i = 0; i < n_s; i++) begin
      check("load_ready_s", o_load_ready, 1);
      i_s_valid = 1; i_s_sym = s_syms[i]; i_s_last = (i == n_s - 1);
      tick();
      i_s_valid = 0; i_s_last = 0;
    end
  endtask

  task automatic load_t_all(input int n_t);
    ent_t e;
    for (int i = 0; i < n_t; i++) begin
      e.t = 2'($urandom); e.v = '0; e.f = '0;
      fifo_q.push_back(e);
      check("load_ready_t", o_load_ready, 1);
      i_t_load_valid = 1; i_t_sym = e.t; i_t_load_last = (i == n_t - 1);
      tick();
      i_t_load_valid = 0; i_t_load_last = 0;
    end
  endtask

  task automatic pulse_start();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  // Plays the array's role: serve every chunk, pop and check each T entry,
  // return a fresh entry each pop, advance chunks until the final pass ends.
  task automatic serve(input int n_s, input int n_t, output int chunks, output int last_len);
    ent_t e;
    chunks = 0;
    last_len = -1;
    for (int c = 0; c < SCH; c++) begin
      bit final_p;
      int exp_len;
      final_p = ((c + 1) * PE >= n_s);
      exp_len = final_p ? (n_s - c * PE) : PE;
      check("data_valid", o_data_valid, 1);
      check("s_chunk", o_s, pack_chunk(c, n_s));
      check("s_len", o_init_s_len, exp_len);
      check("s_last", o_s_last, final_p);
      if (final_p) begin
        i_update_s_w = 1;
        tick();
        i_update_s_w = 0;
        check("s_last_hold", o_s_last, 1);
        check("s_len_hold", o_init_s_len, exp_len);
      end
      for (int j = 0; j < n_t; j++) begin
        if ($urandom_range(0, 3) == 0) tick();
        check("head_t", o_t, fifo_q[0].t);
        check("head_v", o_v, fifo_q[0].v);
        check("head_f", o_f, fifo_q[0].f);
        check("t_last", o_t_last, (j == n_t - 1));
        e.t = 2'($urandom); e.v = VEF'($urandom); e.f = VEF'($urandom);
        i_update_t_w = 1; i_t_valid = 1; i_t = e.t; i_v = e.v; i_f = e.f;
        tick();
        i_update_t_w = 0; i_t_valid = 0;
        void'(fifo_q.pop_front());
        if (!final_p) fifo_q.push_back(e);
        if (j < n_t - 1) check("done_early", o_done, 0);
      end
      chunks++;
      if (final_p) begin
        last_len = exp_len;
        check("done_pulse", o_done, 1);
        check("busy_in_done", o_busy, 0);
        tick();
        check("done_one_cycle", o_done, 0);
        check("idle_valid", o_data_valid, 0);
        check("idle_ready", o_load_ready, 1);
        break;
      end
      i_update_s_w = 1;
      tick();
      i_update_s_w = 0;
    end
  endtask

  task automatic run_scenario(input int n_s, input int n_t, output int chunks, output int last_len);
    s_syms.delete();
    fifo_q.delete();
    for (int i = 0; i < n_s; i++) s_syms.push_back(2'($urandom));
    // Full S storage withholds load_ready, so T goes first in that case.
    if (n_s == S_MAX) begin
      load_t_all(n_t);
      pulse_start();
      check("start_ignored", o_data_valid, 0);
      load_s_all(n_s);
    end else begin
      load_s_all(n_s);
      pulse_start();
      check("start_ignored", o_data_valid, 0);
      load_t_all(n_t);
    end
    check("busy_load", o_busy, 1);
    check("valid_load", o_data_valid, 0);
    if (n_s == S_MAX || n_t == TD) begin
      check("ready_full", o_load_ready, 0);
      i_t_load_valid = 1; i_t_sym = 2'($urandom);
      tick();
      i_t_load_valid = 0;
    end
    pulse_start();
    serve(n_s, n_t, chunks, last_len);
    check("err_clean", o_err, 0);
  endtask

  vec_t vecs[7];
  int   chunks, last_len;

  initial begin
    vecs[0] = '{n_s: 64,  n_t: 10,  exp_chunks: 1, exp_last_len: 64};
    vecs[1] = '{n_s: 70,  n_t: 10,  exp_chunks: 2, exp_last_len: 6};
    vecs[2] = '{n_s: 70,  n_t: 5,   exp_chunks: 2, exp_last_len: 6};
    vecs[3] = '{n_s: 1,   n_t: 1,   exp_chunks: 1, exp_last_len: 1};
    vecs[4] = '{n_s: 256, n_t: 3,   exp_chunks: 4, exp_last_len: 64};
    vecs[5] = '{n_s: 129, n_t: 7,   exp_chunks: 3, exp_last_len: 1};
    vecs[6] = '{n_s: 1,   n_t: 256, exp_chunks: 1, exp_last_len: 1};

    clear_inputs();
    rst_n = 0;
    #2;
    check_reset_outputs();
    tick();
    tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_scenario(vecs[i].n_s, vecs[i].n_t, chunks, last_len);
      check("vec_chunks", chunks, vecs[i].exp_chunks);
      check("vec_last_len", last_len, vecs[i].exp_last_len);
    end

    // Pop on an empty FIFO: head stays zero, error flag depends on build.
    i_update_t_w = 1;
    tick();
    i_update_t_w = 0;
    check("underflow_head_t", o_t, 0);
    check("underflow_head_v", o_v, 0);
    check("underflow_err", o_err, ERR_EN);
    apply_reset();

    // A return while loading is an error in the checked build.
    s_syms.delete();
    s_syms.push_back(2'b10);
    load_s_all(1);
    i_t_valid = 1;
    tick();
    i_t_valid = 0;
    check("ret_in_load_err", o_err, ERR_EN);
    apply_reset();

    // Reset in the middle of a pass, then a clean job.
    s_syms.delete();
    fifo_q.delete();
    for (int i = 0; i < 70; i++) s_syms.push_back(2'($urandom));
    load_s_all(70);
    load_t_all(5);
    pulse_start();
    check("mid_valid", o_data_valid, 1);
    for (int j = 0; j < 2; j++) begin
      check("mid_head", o_t, fifo_q[0].t);
      i_update_t_w = 1; i_t_valid = 1; i_t = 2'($urandom);
      tick();
      i_update_t_w = 0; i_t_valid = 0;
      void'(fifo_q.pop_front());
    end
    apply_reset();
    run_scenario(64, 10, chunks, last_len);
    check("post_rst_chunks", chunks, 1);
    check("post_rst_last_len", last_len, 64);

    // Randomized jobs against the model.
    for (int r = 0; r < 8; r++) begin
      int ns, nt;
      ns = $urandom_range(1, S_MAX);
      nt = $urandom_range(1, 20);
      run_scenario(ns, nt, chunks, last_len);
      check("rand_chunks", chunks, (ns + PE - 1) / PE);
      check("rand_last_len", last_len, ns - ((ns + PE - 1) / PE - 1) * PE);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
